// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RV32I control FSM with shared memory port and wait watchdog
module mc_controller #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       RegWrite,
    output logic       CSRWrite,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       InstrRetired,
    output logic       Illegal,
    output logic       BusErr,
    output logic [3:0] State
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_CSR      = 4'd13
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            wd_limit;

    assign wd_limit = (wait_cnt_q == CW'(WAIT_LIMIT));
    assign State    = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Everything defaults low; reset holds the whole output set at zero.
    always_comb begin
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCUpdate     = 1'b0;
        RegWrite     = 1'b0;
        CSRWrite     = 1'b0;
        ImmSrc       = 3'b000;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        ResultSrc    = 2'b00;
        InstrRetired = 1'b0;
        Illegal      = 1'b0;
        BusErr       = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemReq = 1'b1;
                    if (MemReady) begin
                        IRWrite   = 1'b1;
                        PCUpdate  = 1'b1;
                        ALUSrcB   = 2'b10;
                        ResultSrc = 2'b10;
                        state_d   = S_DECODE;
                    end else if (wd_limit) begin
                        BusErr  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
                    case (op)
                        OP_LOAD: begin
                            if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
                                Illegal = 1'b1;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_MEMADR;
                            end
                        end
                        OP_STORE: begin
                            if (funct3 > 3'b010) begin
                                Illegal = 1'b1;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_MEMADR;
                            end
                        end
                        OP_BRANCH: begin
                            if (funct3[2:1] != 2'b00) begin
                                Illegal = 1'b1;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_BRANCH;
                            end
                        end
                        OP_RTYPE: state_d = S_EXECR;
                        OP_ITYPE: state_d = S_EXECI;
                        OP_JAL:   state_d = S_JAL;
                        OP_LUI:   state_d = S_LUI;
                        OP_AUIPC: state_d = S_AUIPC;
                        OP_CSR:   state_d = S_CSR;
                        default: begin
                            Illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    if (op == OP_STORE) begin
                        ImmSrc  = 3'b001;
                        state_d = S_MEMWRITE;
                    end else begin
                        state_d = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                    if (MemReady) begin
                        state_d = S_MEMWB;
                    end else if (wd_limit) begin
                        BusErr  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_MEMWB: begin
                    ResultSrc    = 2'b01;
                    RegWrite     = 1'b1;
                    InstrRetired = 1'b1;
                    state_d      = S_FETCH;
                end
                S_MEMWRITE: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    if (MemReady) begin
                        InstrRetired = 1'b1;
                        state_d      = S_FETCH;
                    end else if (wd_limit) begin
                        BusErr  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                    state_d = S_ALUWB;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite     = 1'b1;
                    InstrRetired = 1'b1;
                    state_d      = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA      = 2'b10;
                    ALUOp        = 2'b01;
                    PCUpdate     = funct3[0] ? ~Zero : Zero;
                    InstrRetired = 1'b1;
                    state_d      = S_FETCH;
                end
                S_JAL: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    PCUpdate = 1'b1;
                    state_d  = S_ALUWB;
                end
                S_LUI: begin
                    ALUSrcA = 2'b11;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 3'b100;
                    state_d = S_ALUWB;
                end
                S_AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 3'b100;
                    state_d = S_ALUWB;
                end
                S_CSR: begin
                    ResultSrc    = 2'b11;
                    RegWrite     = 1'b1;
                    CSRWrite     = 1'b1;
                    InstrRetired = 1'b1;
                    state_d      = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase

            // Counter restarts whenever a state is entered, a transfer completes or the watchdog fires.
            if (state_d != state_q || MemReady || BusErr) begin
                wait_cnt_d = '0;
            end else if (MemReq) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       MemReady;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCUpdate, RegWrite, CSRWrite;
    logic [2:0] ImmSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic       InstrRetired, Illegal, BusErr;
    logic [3:0] State;

    int n_tests = 0;
    int n_fail  = 0;

    int         r_cycles, r_regw, r_irw, r_ret, r_ill, r_bus, r_csrw;
    int         r_rw_rs01, r_pcu_br, r_memw;
    logic [3:0] r_regw_state;
    logic [3:0] r_trace [0:63];
    logic       r_done;

    mc_controller #(.WAIT_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .Zero         (Zero),
        .MemReady     (MemReady),
        .MemReq       (MemReq),
        .MemWrite     (MemWrite),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .PCUpdate     (PCUpdate),
        .RegWrite     (RegWrite),
        .CSRWrite     (CSRWrite),
        .ImmSrc       (ImmSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .ResultSrc    (ResultSrc),
        .InstrRetired (InstrRetired),
        .Illegal      (Illegal),
        .BusErr       (BusErr),
        .State        (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses reset and releases it on a falling edge: caller resumes in the first FETCH cycle.
    task automatic apply_reset;
        @(negedge clk);
        reset    = 1'b1;
        MemReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input logic rdy, input logic z);
        MemReady = rdy;
        Zero     = z;
        #1;
    endtask

    // Runs one instruction from FETCH, inserting fw/mw wait cycles, until a retire/illegal/bus-error pulse.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic z,
                       input int fw, input int mw);
        int   fwait, mwait;
        logic rdy;
        fwait = fw;
        mwait = mw;
        op = o;
        funct3 = f3;
        r_cycles = 0; r_regw = 0; r_irw = 0; r_ret = 0; r_ill = 0; r_bus = 0;
        r_csrw = 0; r_rw_rs01 = 0; r_pcu_br = 0; r_memw = 0;
        r_regw_state = 4'hf;
        r_done = 1'b0;
        while (!r_done && r_cycles < 60) begin
            rdy = 1'b1;
            if (State == 4'd0 && fwait > 0) begin
                rdy = 1'b0;
                fwait--;
            end
            if ((State == 4'd3 || State == 4'd5) && mwait > 0) begin
                rdy = 1'b0;
                mwait--;
            end
            drive(rdy, z);
            r_trace[r_cycles] = State;
            if (RegWrite) begin
                r_regw++;
                r_regw_state = State;
                if (ResultSrc == 2'b01) r_rw_rs01++;
            end
            if (IRWrite)              r_irw++;
            if (InstrRetired)         r_ret++;
            if (Illegal)              r_ill++;
            if (BusErr)               r_bus++;
            if (CSRWrite)             r_csrw++;
            if (MemWrite)             r_memw++;
            if (PCUpdate && State == 4'd9) r_pcu_br++;
            if (InstrRetired || Illegal || BusErr) r_done = 1'b1;
            r_cycles++;
            @(negedge clk);
        end
        n_tests++;
        if (!r_done) begin
            n_fail++;
            $display("FAIL run_timeout op=%b: instruction did not end, cycles=%0d required <60", o, r_cycles);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        op = 7'b0110011;
        funct3 = 3'b000;
        drive(1'b1, 1'b1);
        n_tests++;
        if ({MemReq, MemWrite, AdrSrc, IRWrite, PCUpdate, RegWrite, CSRWrite, ImmSrc, ALUSrcA,
             ALUSrcB, ALUOp, ResultSrc, InstrRetired, Illegal, BusErr, State} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got MemReq=%b IRWrite=%b State=%0d, required all zero",
                     MemReq, IRWrite, State);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        n_tests++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required 0", State);
        end
        n_tests++;
        if (MemReq !== 1'b1 || AdrSrc !== 1'b0 || MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_req: got MemReq=%b AdrSrc=%b MemWrite=%b required 1 0 0",
                     MemReq, AdrSrc, MemWrite);
        end
    endtask

    task automatic test_rtype;
        apply_reset();
        run(7'b0110011, 3'b000, 1'b0, 0, 0);
        n_tests++;
        if (r_cycles !== 4) begin
            n_fail++;
            $display("FAIL rtype_cycles: got %0d required 4", r_cycles);
        end
        n_tests++;
        if ({r_trace[0], r_trace[1], r_trace[2], r_trace[3]} !== {4'd0, 4'd1, 4'd6, 4'd8}) begin
            n_fail++;
            $display("FAIL rtype_states: got %0d,%0d,%0d,%0d required 0,1,6,8",
                     r_trace[0], r_trace[1], r_trace[2], r_trace[3]);
        end
        n_tests++;
        if (r_regw !== 1 || r_regw_state !== 4'd8 || r_ret !== 1 || r_irw !== 1) begin
            n_fail++;
            $display("FAIL rtype_enables: got regw=%0d in state %0d ret=%0d irw=%0d required 1 in 8, 1, 1",
                     r_regw, r_regw_state, r_ret, r_irw);
        end
    endtask

    task automatic test_lw_waits;
        apply_reset();
        run(7'b0000011, 3'b010, 1'b0, 3, 2);
        n_tests++;
        if (r_cycles !== 10) begin
            n_fail++;
            $display("FAIL lw_cycles: got %0d required 10", r_cycles);
        end
        n_tests++;
        if (r_irw !== 1 || r_rw_rs01 !== 1 || r_regw !== 1 || r_ret !== 1 || r_bus !== 0) begin
            n_fail++;
            $display("FAIL lw_enables: got irw=%0d rw_rs01=%0d regw=%0d ret=%0d bus=%0d required 1 1 1 1 0",
                     r_irw, r_rw_rs01, r_regw, r_ret, r_bus);
        end
    endtask

    task automatic test_branch;
        apply_reset();
        run(7'b1100011, 3'b000, 1'b1, 0, 0);
        n_tests++;
        if (r_cycles !== 3 || r_pcu_br !== 1 || r_ret !== 1) begin
            n_fail++;
            $display("FAIL beq_taken: got cycles=%0d pcupd=%0d ret=%0d required 3 1 1",
                     r_cycles, r_pcu_br, r_ret);
        end
        run(7'b1100011, 3'b001, 1'b1, 0, 0);
        n_tests++;
        if (r_cycles !== 3 || r_pcu_br !== 0 || r_ret !== 1) begin
            n_fail++;
            $display("FAIL bne_not_taken: got cycles=%0d pcupd=%0d ret=%0d required 3 0 1",
                     r_cycles, r_pcu_br, r_ret);
        end
    endtask

    task automatic test_illegal;
        apply_reset();
        run(7'b1111111, 3'b000, 1'b0, 0, 0);
        n_tests++;
        if (r_cycles !== 2 || r_ill !== 1 || r_regw !== 0 || r_ret !== 0) begin
            n_fail++;
            $display("FAIL illegal_op: got cycles=%0d ill=%0d regw=%0d ret=%0d required 2 1 0 0",
                     r_cycles, r_ill, r_regw, r_ret);
        end
        drive(1'b0, 1'b0);
        n_tests++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL illegal_return: got state %0d required 0", State);
        end
        run(7'b0100011, 3'b011, 1'b0, 0, 0);
        n_tests++;
        if (r_cycles !== 2 || r_ill !== 1 || r_memw !== 0 || r_ret !== 0) begin
            n_fail++;
            $display("FAIL illegal_store: got cycles=%0d ill=%0d memw=%0d ret=%0d required 2 1 0 0",
                     r_cycles, r_ill, r_memw, r_ret);
        end
    endtask

    task automatic test_bus_err;
        apply_reset();
        run(7'b0100011, 3'b010, 1'b0, 0, 100);
        n_tests++;
        if (r_bus !== 1 || r_cycles !== 8 || r_memw !== 5 || r_ret !== 0) begin
            n_fail++;
            $display("FAIL buserr_timing: got bus=%0d cycles=%0d memw=%0d ret=%0d required 1 8 5 0",
                     r_bus, r_cycles, r_memw, r_ret);
        end
        drive(1'b0, 1'b0);
        n_tests++;
        if (State !== 4'd0 || MemWrite !== 1'b0 || MemReq !== 1'b1 || AdrSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL buserr_retry: got State=%0d MemWrite=%b MemReq=%b AdrSrc=%b required 0 0 1 0",
                     State, MemWrite, MemReq, AdrSrc);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        op = 7'b0100011;
        funct3 = 3'b010;
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0);
        n_tests++;
        if (State !== 4'd5 || MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: got State=%0d MemWrite=%b required 5 1", State, MemWrite);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (MemReq !== 1'b0 || MemWrite !== 1'b0 || State !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_drop: got MemReq=%b MemWrite=%b State=%0d required 0 0 0",
                     MemReq, MemWrite, State);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        n_tests++;
        if (State !== 4'd0 || MemReq !== 1'b1 || AdrSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_release: got State=%0d MemReq=%b AdrSrc=%b required 0 1 0",
                     State, MemReq, AdrSrc);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] ops  [0:5];
        logic [2:0] f3s  [0:5];
        int         exps [0:5];
        ops[0] = 7'b1101111; f3s[0] = 3'b000; exps[0] = 4;
        ops[1] = 7'b0110111; f3s[1] = 3'b000; exps[1] = 4;
        ops[2] = 7'b0010111; f3s[2] = 3'b000; exps[2] = 4;
        ops[3] = 7'b1110011; f3s[3] = 3'b001; exps[3] = 3;
        ops[4] = 7'b0100011; f3s[4] = 3'b010; exps[4] = 4;
        ops[5] = 7'b0010011; f3s[5] = 3'b000; exps[5] = 4;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run(ops[i], f3s[i], 1'b0, 0, 0);
            n_tests++;
            if (r_cycles !== exps[i] || r_ret !== 1 || r_ill !== 0) begin
                n_fail++;
                $display("FAIL b2b_op%0d: got cycles=%0d ret=%0d ill=%0d required %0d 1 0",
                         i, r_cycles, r_ret, r_ill, exps[i]);
            end
            n_tests++;
            if (r_csrw !== ((i == 3) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL b2b_csrwrite%0d: got %0d required %0d", i, r_csrw, (i == 3) ? 1 : 0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        op       = 7'd0;
        funct3   = 3'd0;
        Zero     = 1'b0;
        MemReady = 1'b0;
        test_reset();
        test_rtype();
        test_lw_waits();
        test_branch();
        test_illegal();
        test_bus_err();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the RV32I core: sequences one shared ALU, one shared instruction/data memory port and the register file/CSR write enables across the FETCH/DECODE/EXECUTE/WRITEBACK steps of each instruction. It supports the same opcode set as the single-cycle main decoder: loads, stores, R-type, I-type ALU, beq/bne, jal, lui, auipc and csr. It also handles a ready-based memory handshake with a wait-cycle watchdog.

## Interface
- WAIT_LIMIT, 255: max consecutive wait cycles in one memory state before a bus error; width of wait counter = $clog2(WAIT_LIMIT+1).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; one clock domain (clk).
- op  in  7  opcode from instruction register, stable from DECODE to end of instruction.
- funct3  in  3  funct3 from instruction register.
- Zero  in  1  ALU zero flag, combinational from current ALU inputs.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  write strobe, valid with MemReq.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register and OldPC.
- PCUpdate  out  1  load PC from Result.
- RegWrite  out  1  register-file write.
- CSRWrite  out  1  CSR write.
- ImmSrc  out  3  I 000, S 001, B 010, J 011, U 100.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero.
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- ALUOp  out  2  00 add, 01 sub, 10 funct decode.
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult, 11 CSR read data.
- InstrRetired  out  1  one-cycle pulse on the final cycle of a legal instruction.
- Illegal  out  1  one-cycle pulse on an unsupported op/funct3.
- BusErr  out  1  one-cycle pulse on watchdog expiry.
- State  out  4  current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, AUIPC 12, CSR 13
  - Encodings 14 and 15 go to FETCH.
- Unlisted outputs in every state: enables 0, selects 00, ImmSrc 000.
- FETCH: MemReq=1, AdrSrc=0.
  - If MemReady: IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; go to DECODE.
  - Otherwise stay in FETCH with no write enables.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=011 if op=jal else 010 (ALUOut holds the branch/jump target).
  - load or store → MEMADR; R-type → EXECR; I-ALU → EXECI; branch → BRANCH; jal → JAL; lui → LUI; auipc → AUIPC; csr → CSR.
  - Illegal cases: any other op, load funct3 ∈ {011,110,111}, store funct3 > 010, branch funct3 ∉ {000,001}. For these: Illegal=1 and go to FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000 for load / 001 for store. Next state: MEMREAD for load, MEMWRITE for store.
- MEMREAD: MemReq=1, AdrSrc=1. On MemReady go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrRetired=1; go to FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. On MemReady: InstrRetired=1, go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrRetired=1; go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCUpdate=Zero for beq (funct3 000), ~Zero for bne (funct3 001).
  - InstrRetired=1; go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; go to ALUWB (rd ← OldPC+4).
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=100; go to ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=100; go to ALUWB.
- CSR: ResultSrc=11, RegWrite=1, CSRWrite=1, InstrRetired=1; go to FETCH.
- Watchdog:
  - Counter clears on entry to FETCH, MEMREAD or MEMWRITE, and on MemReady.
  - Increments each cycle MemReq=1 && MemReady=0.
  - When it would exceed WAIT_LIMIT: BusErr=1, MemReq stays 1 that cycle, no write enables, go to FETCH.
  - The PC is unchanged, so FETCH retries the same address.

## Timing
- Reset (async, immediate): state=FETCH, counter=0.
  - All outputs are 0 while reset=1, MemReq and MemWrite included.
  - The first MemReq is asserted in the first cycle after reset deasserts.
- Reset mid-operation: the pending memory access is abandoned; no partial RegWrite/CSRWrite/MemWrite may occur.
- Outputs are Moore-decoded from state, except terms gated by MemReady or Zero, which are combinational in the same cycle.
- Cycle counts with zero wait states:
  - lw 5; sw 4; R/I-type 4; beq/bne 3; jal 4; lui/auipc 4; csr 3.
  - Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- MemReq/AdrSrc/MemWrite stay stable while waiting.
- At most one of InstrRetired/Illegal/BusErr pulses per cycle.

## Test plan
- R-type add, MemReady tied 1 → states 0,1,6,8,0; RegWrite only in ALUWB; InstrRetired pulses once; 4 cycles.
- lw with 3 wait cycles in FETCH and 2 in MEMREAD → 10 cycles total; IRWrite once; RegWrite with ResultSrc=01 exactly once.
- beq with Zero=1, then bne with Zero=1 → PCUpdate=1 in BRANCH for beq, 0 for bne; both retire in 3 cycles.
- op=7'b1111111 → Illegal pulse in DECODE, back to FETCH, no RegWrite/InstrRetired; same for store funct3=011.
- WAIT_LIMIT=4, MemReady held 0 in MEMWRITE → BusErr on the 5th wait cycle, return to FETCH, MemWrite drops the following cycle.
- Reset asserted during MEMWRITE wait → MemReq/MemWrite drop in the same cycle; after release, State=0 and MemReq=1 with AdrSrc=0.
